// File: rtl/sys_cmd_master.sv
// sys_cmd_master
// Host-side command initiator for the UART register-file / ALU command
// protocol. A parallel command request is turned into the byte stream the
// system controller expects. Each byte goes to a UART TX over a valid/ready
// handshake. Response bytes from a UART RX are then gathered into a result,
// and a per-byte timeout aborts the wait if no byte arrives.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready command handshake; fields captured on acceptance
//   cmd_type        00 write, 01 read, 10 ALU with operands, 11 ALU no operands
//   cmd_addr        register address (zero-extended into a byte)
//   cmd_wdata       write data
//   cmd_op_a/op_b   ALU operands
//   cmd_func        ALU function (zero-extended into a byte)
//   tx_data/valid   byte to the UART TX, tx_ready accepts it
//   rx_data/valid   received byte, rx_valid is a single-cycle pulse
//   rsp_data        assembled response (low byte first), held until the next success
//   rsp_valid       one-cycle pulse on a successful read / ALU response
//   rsp_timeout     one-cycle pulse when the response times out
//   cmd_done        one-cycle pulse when the command finishes
module sys_cmd_master #(
   parameter int FRAME_WIDTH         = 8,
   parameter int ALU_DATA_WIDTH      = 16,
   parameter int ALU_FUNC_WIDTH      = 4,
   parameter int REG_FILE_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES      = 65535
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_type,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [FRAME_WIDTH-1:0]         cmd_wdata,
   input  logic [FRAME_WIDTH-1:0]         cmd_op_a,
   input  logic [FRAME_WIDTH-1:0]         cmd_op_b,
   input  logic [ALU_FUNC_WIDTH-1:0]      cmd_func,
   output logic [FRAME_WIDTH-1:0]         tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   input  logic [FRAME_WIDTH-1:0]         rx_data,
   input  logic                           rx_valid,
   output logic [ALU_DATA_WIDTH-1:0]      rsp_data,
   output logic                           rsp_valid,
   output logic                           rsp_timeout,
   output logic                           cmd_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_RSP, ST_DONE} state_t;

   localparam logic [1:0] TYPE_WR     = 2'b00;
   localparam logic [1:0] TYPE_RD     = 2'b01;
   localparam logic [1:0] TYPE_ALU    = 2'b10;
   localparam logic [1:0] TYPE_ALU_NO = 2'b11;

   localparam logic [FRAME_WIDTH-1:0] HDR_WR     = FRAME_WIDTH'(8'hAA);
   localparam logic [FRAME_WIDTH-1:0] HDR_RD     = FRAME_WIDTH'(8'hBB);
   localparam logic [FRAME_WIDTH-1:0] HDR_ALU    = FRAME_WIDTH'(8'hCC);
   localparam logic [FRAME_WIDTH-1:0] HDR_ALU_NO = FRAME_WIDTH'(8'hDD);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // The counter holds k-1 in the k-th waiting cycle, so leaving at
   // TIMEOUT_CYCLES-1 puts DONE exactly TIMEOUT_CYCLES edges after the
   // last byte handshake.
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                         state_reg, state_next;
   logic [1:0]                     idx_reg, idx_next;
   logic [1:0]                     type_reg, type_next;
   logic [REG_FILE_ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [FRAME_WIDTH-1:0]         wdata_reg, wdata_next;
   logic [FRAME_WIDTH-1:0]         op_a_reg, op_a_next;
   logic [FRAME_WIDTH-1:0]         op_b_reg, op_b_next;
   logic [ALU_FUNC_WIDTH-1:0]      func_reg, func_next;
   logic [CNT_W-1:0]               cnt_reg, cnt_next;
   logic                           rx_cnt_reg, rx_cnt_next;
   logic [FRAME_WIDTH-1:0]         byte0_reg, byte0_next;
   logic [ALU_DATA_WIDTH-1:0]      rsp_data_reg, rsp_data_next;
   logic                           timeout_reg, timeout_next;

   logic [FRAME_WIDTH-1:0]         seq_byte;
   logic [1:0]                     last_idx;

   // Current byte of the outgoing sequence and the index of its last byte.
   always_comb begin
      seq_byte = '0;
      last_idx = 2'd1;
      case (type_reg)
         TYPE_WR: begin
            last_idx = 2'd2;
            case (idx_reg)
               2'd0:    seq_byte = HDR_WR;
               2'd1:    seq_byte = FRAME_WIDTH'(addr_reg);
               default: seq_byte = wdata_reg;
            endcase
         end
         TYPE_RD: begin
            seq_byte = (idx_reg == 2'd0) ? HDR_RD : FRAME_WIDTH'(addr_reg);
         end
         TYPE_ALU: begin
            last_idx = 2'd3;
            case (idx_reg)
               2'd0:    seq_byte = HDR_ALU;
               2'd1:    seq_byte = op_a_reg;
               2'd2:    seq_byte = op_b_reg;
               default: seq_byte = FRAME_WIDTH'(func_reg);
            endcase
         end
         default: begin
            seq_byte = (idx_reg == 2'd0) ? HDR_ALU_NO : FRAME_WIDTH'(func_reg);
         end
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      type_next     = type_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      op_a_next     = op_a_reg;
      op_b_next     = op_b_reg;
      func_next     = func_reg;
      cnt_next      = cnt_reg;
      rx_cnt_next   = rx_cnt_reg;
      byte0_next    = byte0_reg;
      rsp_data_next = rsp_data_reg;
      timeout_next  = timeout_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               type_next  = cmd_type;
               addr_next  = cmd_addr;
               wdata_next = cmd_wdata;
               op_a_next  = cmd_op_a;
               op_b_next  = cmd_op_b;
               func_next  = cmd_func;
               idx_next   = 2'd0;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               timeout_next = 1'b0;
               if (idx_reg != last_idx) begin
                  idx_next = idx_reg + 2'd1;
               end else if (type_reg == TYPE_WR) begin
                  state_next = ST_DONE;
               end else begin
                  cnt_next    = '0;
                  rx_cnt_next = 1'b0;
                  state_next  = ST_WAIT_RSP;
               end
            end
         end
         ST_WAIT_RSP: begin
            // A byte arriving on the limit cycle still counts.
            if (rx_valid) begin
               cnt_next    = '0;
               rx_cnt_next = 1'b1;
               if (type_reg == TYPE_RD) begin
                  rsp_data_next = ALU_DATA_WIDTH'(rx_data);
                  state_next    = ST_DONE;
               end else if (!rx_cnt_reg) begin
                  byte0_next = rx_data;
               end else begin
                  rsp_data_next = ALU_DATA_WIDTH'({rx_data, byte0_reg});
                  state_next    = ST_DONE;
               end
            end else if (cnt_reg == CNT_LIMIT) begin
               timeout_next = 1'b1;
               state_next   = ST_DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg    <= ST_IDLE;
         idx_reg      <= '0;
         type_reg     <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         func_reg     <= '0;
         cnt_reg      <= '0;
         rx_cnt_reg   <= 1'b0;
         byte0_reg    <= '0;
         rsp_data_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         type_reg     <= type_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         op_a_reg     <= op_a_next;
         op_b_reg     <= op_b_next;
         func_reg     <= func_next;
         cnt_reg      <= cnt_next;
         rx_cnt_reg   <= rx_cnt_next;
         byte0_reg    <= byte0_next;
         rsp_data_reg <= rsp_data_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign cmd_ready   = (state_reg == ST_IDLE);
   assign tx_valid    = (state_reg == ST_SEND);
   assign tx_data     = (state_reg == ST_SEND) ? seq_byte : '0;
   assign cmd_done    = (state_reg == ST_DONE);
   assign rsp_valid   = (state_reg == ST_DONE) && !timeout_reg && (type_reg != TYPE_WR);
   assign rsp_timeout = (state_reg == ST_DONE) && timeout_reg;
   assign rsp_data    = rsp_data_reg;

endmodule

// File: tb/tb_sys_cmd_master.sv
module tb_sys_cmd_master;

   logic        CLK;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [7:0]  cmd_op_a;
   logic [7:0]  cmd_op_b;
   logic [3:0]  cmd_func;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] rsp_data;
   logic        rsp_valid;
   logic        rsp_timeout;
   logic        cmd_done;

   int vectors     = 0;
   int miscompares = 0;

   sys_cmd_master #(
      .FRAME_WIDTH        (8),
      .ALU_DATA_WIDTH     (16),
      .ALU_FUNC_WIDTH     (4),
      .REG_FILE_ADDR_WIDTH(4),
      .TIMEOUT_CYCLES     (32)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_type   (cmd_type),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_op_a   (cmd_op_a),
      .cmd_op_b   (cmd_op_b),
      .cmd_func   (cmd_func),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rsp_data   (rsp_data),
      .rsp_valid  (rsp_valid),
      .rsp_timeout(rsp_timeout),
      .cmd_done   (cmd_done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a command for one cycle, then scramble the inputs so that any
   // late sampling of them shows up in the transmitted bytes.
   task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      cmd_type  = t;
      cmd_addr  = a;
      cmd_wdata = wd;
      cmd_op_a  = oa;
      cmd_op_b  = ob;
      cmd_func  = f;
      cmd_valid = 1'b1;
      check("cmd_ready_at_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_type  = ~t;
      cmd_addr  = ~a;
      cmd_wdata = ~wd;
      cmd_op_a  = ~oa;
      cmd_op_b  = ~ob;
      cmd_func  = ~f;
      $display("cmd type=%0d addr=0x%0h wdata=0x%0h op_a=0x%0h op_b=0x%0h func=0x%0h", t, a, wd, oa, ob, f);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, tx_valid, 1);
      check(tag, tx_data, exp);
      $display("tx byte 0x%0h (expected 0x%0h)", tx_data, exp);
      tick();
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      $display("rx byte 0x%0h", b);
   endtask

   initial begin
      RST       = 1'b0;
      cmd_valid = 1'b0;
      cmd_type  = '0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_op_a  = '0;
      cmd_op_b  = '0;
      cmd_func  = '0;
      tx_ready  = 1'b1;
      rx_data   = '0;
      rx_valid  = 1'b0;
      #22;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_cmd_done", cmd_done, 0);
      RST = 1'b1;
      tick();

      // Write: AA, 00, 02, no response expected.
      send_cmd(2'b00, 4'h0, 8'h02, 8'h00, 8'h00, 4'h0);
      expect_byte("wr_b0", 8'hAA);
      expect_byte("wr_b1", 8'h00);
      expect_byte("wr_b2", 8'h02);
      check("wr_done", cmd_done, 1);
      check("wr_rsp_valid", rsp_valid, 0);
      check("wr_timeout", rsp_timeout, 0);
      check("wr_ready_in_done", cmd_ready, 0);
      tick();
      check("wr_ready_after", cmd_ready, 1);
      check("wr_done_after", cmd_done, 0);

      // Read: BB, 00; response 0x02 arrives ten cycles after the last byte.
      send_cmd(2'b01, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
      expect_byte("rd_b0", 8'hBB);
      expect_byte("rd_b1", 8'h00);
      for (int i = 0; i < 9; i++) begin
         check("rd_wait_tx_valid", tx_valid, 0);
         check("rd_wait_done", cmd_done, 0);
         tick();
      end
      rx_byte(8'h02);
      check("rd_done", cmd_done, 1);
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_data", rsp_data, 16'h0002);
      tick();

      // ALU with operands: CC, A9, 08, 02; response A1 then 00.
      send_cmd(2'b10, 4'h0, 8'h00, 8'hA9, 8'h08, 4'h2);
      expect_byte("alu_b0", 8'hCC);
      expect_byte("alu_b1", 8'hA9);
      expect_byte("alu_b2", 8'h08);
      expect_byte("alu_b3", 8'h02);
      rx_byte(8'hA1);
      check("alu_half_done", cmd_done, 0);
      check("alu_half_rsp_valid", rsp_valid, 0);
      check("alu_half_rsp_held", rsp_data, 16'h0002);
      tick();
      tick();
      rx_byte(8'h00);
      check("alu_done", cmd_done, 1);
      check("alu_rsp_valid", rsp_valid, 1);
      check("alu_rsp_data", rsp_data, 16'h00A1);
      tick();

      // ALU without operands: DD, 00 with a 5-cycle stall on byte 1.
      // A stray rx pulse during the stall must be ignored.
      send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
      expect_byte("nop_b0", 8'hDD);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("nop_stall_valid", tx_valid, 1);
         check("nop_stall_data", tx_data, 8'h00);
         rx_valid = (i == 2);
         rx_data  = 8'h77;
         tick();
         rx_valid = 1'b0;
      end
      tx_ready = 1'b1;
      expect_byte("nop_b1", 8'h00);
      rx_byte(8'h05);
      check("nop_half_done", cmd_done, 0);
      rx_byte(8'h00);
      check("nop_done", cmd_done, 1);
      check("nop_rsp_valid", rsp_valid, 1);
      check("nop_rsp_data", rsp_data, 16'h0005);
      tick();

      // Read with no response: timeout 32 edges after the last handshake.
      send_cmd(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      expect_byte("to_b0", 8'hBB);
      expect_byte("to_b1", 8'h03);
      for (int i = 0; i < 32; i++) begin
         check("to_early_done", cmd_done, 0);
         tick();
      end
      check("to_done", cmd_done, 1);
      check("to_timeout", rsp_timeout, 1);
      check("to_rsp_valid", rsp_valid, 0);
      check("to_rsp_held", rsp_data, 16'h0005);
      tick();
      check("to_ready_after", cmd_ready, 1);
      check("to_timeout_after", rsp_timeout, 0);

      // Reset while ALU byte 2 is on the bus.
      send_cmd(2'b10, 4'h0, 8'h00, 8'hA9, 8'h08, 4'h2);
      expect_byte("rst_alu_b0", 8'hCC);
      expect_byte("rst_alu_b1", 8'hA9);
      check("rst_alu_b2", tx_data, 8'h08);
      #2;
      RST = 1'b0;
      #1;
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_rsp_data", rsp_data, 0);
      check("mid_rst_cmd_done", cmd_done, 0);
      #2;
      RST = 1'b1;
      tick();
      check("post_rst_done", cmd_done, 0);
      check("post_rst_ready", cmd_ready, 1);

      // Follow-up read completes normally.
      send_cmd(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0);
      expect_byte("rd2_b0", 8'hBB);
      expect_byte("rd2_b1", 8'h05);
      tick();
      rx_byte(8'h37);
      check("rd2_done", cmd_done, 1);
      check("rd2_rsp_valid", rsp_valid, 1);
      check("rd2_rsp_data", rsp_data, 16'h0037);
      tick();
      check("rd2_ready_after", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
